mdu_iterative: RTL and testbench

Parametrised multi-cycle multiply/divide unit that follows the single-cycle ALU in the execute stage. It performs signed and unsigned multiply and divide over WIDTH-bit operands. Results go to HI/LO result registers, with overflow and divide-by-zero flags. It uses a start/busy/done handshake, so the pipeline can stall on busy while ordinary ALU ops continue.

---
 rtl/mdu_pkg.sv | 9 +
 rtl/mdu_step.sv | 24 ++
 rtl/mdu_iterative.sv | 100 ++++++++++
 tb/tb_mdu_iterative.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, FSM states and conditional two's-complement negate for the multiply/divide unit
package mdu_pkg;
  localparam int MAX_W = 256;
  typedef enum logic [1:0] {MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  function automatic logic [MAX_W-1:0] cneg(input logic [MAX_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] df;
  logic             ge;
  always_comb begin
    sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    sh    = {acc, q[WIDTH-1]};
    ge    = sh >= {1'b0, m};
    df    = sh[WIDTH-1:0] - m;
    acc_n = div ? (ge ? df : sh[WIDTH-1:0]) : sum[WIDTH:1];
    q_n   = div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle signed/unsigned multiply and divide with start/busy/done handshake
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m_q, acc_n, q_n, ma, mb, quo, rem, hi_n, lo_n;
  logic [W2-1:0]    prod;
  logic             neg_q, rneg_q, dz_q, dov_q, sgn, dz, dov, ovf_n;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div  (op_q[1]),
    .acc  (acc),
    .q    (q),
    .m    (m_q),
    .acc_n(acc_n),
    .q_n  (q_n)
  );
  always_comb begin
    sgn   = ~op[0];
    ma    = WIDTH'(cneg(MAX_W'(a), sgn & a[WIDTH-1]));
    mb    = WIDTH'(cneg(MAX_W'(b), sgn & b[WIDTH-1]));
    dz    = op[1] && b == '0;
    dov   = op == DIV && a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
    prod  = W2'(cneg(MAX_W'({acc, q}), neg_q));
    quo   = WIDTH'(cneg(MAX_W'(q), neg_q));
    rem   = WIDTH'(cneg(MAX_W'(acc), rneg_q));
    hi_n  = dz_q ? acc : op_q[1] ? rem : prod[W2-1:WIDTH];
    lo_n  = dz_q ? q : op_q[1] ? quo : prod[WIDTH-1:0];
    ovf_n = op_q[1] ? dov_q : op_q == MULT && prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m_q      <= '0;
      op_q     <= MULT;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dov_q    <= 1'b0;
    end else if (state == RUN) begin
      if (cnt == CNT_W'(WIDTH)) begin
        state    <= FIN;
        busy     <= 1'b0;
        done     <= 1'b1;
        hi       <= hi_n;
        lo       <= lo_n;
        overflow <= ovf_n;
        div_zero <= dz_q;
      end else begin
        acc <= acc_n;
        q   <= q_n;
        cnt <= cnt + 1'b1;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        state  <= RUN;
        busy   <= 1'b1;
        op_q   <= op_e'(op);
        m_q    <= mb;
        neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_q <= sgn & a[WIDTH-1];
        dz_q   <= dz;
        dov_q  <= dov;
        acc    <= dz ? a : '0;
        q      <= dz ? '1 : ma;
        cnt    <= dz ? CNT_W'(WIDTH) : '0;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed self-checking bench for mdu_iterative at WIDTH=32
module tb_mdu_iterative;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, overflow, div_zero;
  int          errors = 0;
  int          checks = 0;
  int          lat, pulses;
  mdu_iterative #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .overflow(overflow),
    .div_zero(div_zero)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    @(negedge clock);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(n);
  endtask
  task automatic res(input string tag, input int n, input int elat, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic eov, input logic edz);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_ovf"}, overflow, eov);
    chk({tag, "_dz"}, div_zero, edz);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_flags", {overflow, div_zero}, 0);
    @(negedge clock);
    reset = 1'b0;
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, lat);
    res("mult_neg", lat, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    do_op(2'b00, 32'h00010000, 32'h00010000, lat);
    res("mult_ovf", lat, 33, 32'd1, 32'd0, 1'b1, 1'b0);
    do_op(2'b01, 32'h00010000, 32'h00010000, lat);
    res("multu", lat, 33, 32'd1, 32'd0, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, lat);
    res("mult_nn", lat, 33, 32'd0, 32'd20, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    res("multu_max", lat, 33, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat);
    res("div_neg", lat, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, lat);
    res("div_nn", lat, 33, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
    do_op(2'b11, 32'd7, 32'd2, lat);
    res("divu", lat, 33, 32'd1, 32'd3, 1'b0, 1'b0);
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, lat);
    res("divu_big", lat, 33, 32'd1, 32'h7FFFFFFC, 1'b0, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
    res("div_ovf", lat, 33, 32'd0, 32'h80000000, 1'b1, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, lat);
    res("divu_zero", lat, 1, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b1);
    do_op(2'b10, 32'hFFFFFFF0, 32'd0, lat);
    res("div_zero", lat, 1, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    chk("done_pulse", done, 0);
    chk("dz_held", div_zero, 1);
    @(negedge clock);
    start = 1'b1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("hs_busy", busy, 1);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    op = 2'b11;
    a = 32'd9;
    b = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    res("hs_ignore", lat, 33, 32'd0, 32'd12, 1'b0, 1'b0);
    chk("hs_fin_busy", busy, 0);
    start = 1'b1;
    op = 2'b11;
    a = 32'd9;
    b = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    wait_done(lat);
    res("b2b", lat, 33, 32'd0, 32'd3, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b1;
    op = 2'b00;
    a = 32'd1234;
    b = 32'd5678;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    chk("abort_idle", busy, 0);
    do_op(2'b00, 32'd2, 32'd3, lat);
    res("post_rst", lat, 33, 32'd0, 32'd6, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
